// File: rtl/halton_nd.sv
// Multi-dimensional Halton point generator: each pop advances a 32-bit index and emits
// its radical inverse in every base, scaled to an integer by BASES[d]^SCALES[d].
module halton_nd #(
    parameter int unsigned DIM    = 2,
    parameter logic [31:0] BASES  = {8'd7, 8'd5, 8'd3, 8'd2},
    parameter logic [31:0] SCALES = {8'd4, 8'd5, 8'd7, 8'd11}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pop_valid,
    output logic              pop_ready,
    input  logic              reseed_valid,
    input  logic [31:0]       seed,
    output logic              reseed_ready,
    output logic [32*DIM-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    // Saturates just above 2^32-1 so the overflow check cannot wrap.
    function automatic logic [63:0] pow_sat(input logic [7:0] b, input logic [7:0] s);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < int'(s); i++) begin
            r = r * {56'd0, b};
            if (r > 64'h1_0000_0000) r = 64'h1_0000_0000;
        end
        return r;
    endfunction

    state_e      state_q;
    logic [31:0] count_q;
    logic [31:0] k_work_q;
    logic [31:0] res_q;
    logic [31:0] factor_q;
    logic [7:0]  dig_q;
    logic [1:0]  d_q;
    logic [31:0] lane_q [DIM];

    logic [31:0] fact  [4];
    logic [7:0]  scale [4];
    logic [31:0] k_quo [4];
    logic [31:0] k_rem [4];
    logic [31:0] f_quo [4];

    if (DIM < 1 || DIM > 4) begin : g_bad_dim
        $error("halton_nd: DIM must be 1..4");
    end

    // Constant divisors per dimension; the active one is picked by d_q.
    for (genvar g = 0; g < 4; g++) begin : g_dim
        if (g < DIM) begin : g_used
            localparam logic [7:0]  Base  = BASES[8*g +: 8];
            localparam logic [7:0]  Scale = SCALES[8*g +: 8];
            localparam logic [63:0] Pow   = pow_sat(Base, Scale);
            if (Pow > 64'hFFFF_FFFF) begin : g_bad_pow
                $error("halton_nd: BASES^SCALES exceeds 32 bits");
            end
            if (Base < 8'd2) begin : g_bad_base
                $error("halton_nd: base must be 2..255");
            end
            assign fact[g]  = Pow[31:0];
            assign scale[g] = Scale;
            assign k_quo[g] = k_work_q / {24'd0, Base};
            assign k_rem[g] = k_work_q % {24'd0, Base};
            assign f_quo[g] = factor_q / {24'd0, Base};
        end else begin : g_unused
            assign fact[g]  = '0;
            assign scale[g] = '0;
            assign k_quo[g] = '0;
            assign k_rem[g] = '0;
            assign f_quo[g] = '0;
        end
    end

    for (genvar g = 0; g < DIM; g++) begin : g_out
        assign out_data[32*g +: 32] = lane_q[g];
    end

    // Readies are forced low while reset is held.
    assign reseed_ready = rst_n && (state_q == StIdle);
    assign pop_ready    = rst_n && (state_q == StIdle) && !reseed_valid;
    assign out_valid    = (state_q == StHold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            k_work_q <= '0;
            res_q    <= '0;
            factor_q <= '0;
            dig_q    <= '0;
            d_q      <= '0;
            for (int i = 0; i < DIM; i++) lane_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (reseed_valid) begin
                        count_q <= seed;
                    end else if (pop_valid) begin
                        count_q  <= count_q + 32'd1;
                        k_work_q <= count_q + 32'd1;
                        d_q      <= '0;
                        res_q    <= '0;
                        dig_q    <= '0;
                        factor_q <= fact[0];
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (k_work_q != 32'd0 && dig_q < scale[d_q]) begin
                        factor_q <= f_quo[d_q];
                        res_q    <= res_q + k_rem[d_q] * f_quo[d_q];
                        k_work_q <= k_quo[d_q];
                        dig_q    <= dig_q + 8'd1;
                    end else begin
                        for (int i = 0; i < DIM; i++) begin
                            if (int'(d_q) == i) lane_q[i] <= res_q;
                        end
                        if (d_q == 2'(DIM - 1)) begin
                            state_q <= StHold;
                        end else begin
                            d_q      <= d_q + 2'd1;
                            k_work_q <= count_q;
                            res_q    <= '0;
                            dig_q    <= '0;
                            factor_q <= fact[d_q + 2'd1];
                        end
                    end
                end
                StHold: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_halton_nd.sv
// Scoreboard bench for halton_nd with default parameters (bases 2,3; scales 11,7).
module tb_halton_nd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pop_valid = 1'b0;
    logic        reseed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        out_ready = 1'b1;
    logic        pop_ready;
    logic        reseed_ready;
    logic        out_valid;
    logic [63:0] out_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = '0;
    logic [63:0] exp_q[$];

    localparam int unsigned B[2] = '{2, 3};
    localparam int unsigned S[2] = '{11, 7};

    halton_nd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .reseed_valid (reseed_valid),
        .seed         (seed),
        .reseed_ready (reseed_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Digit reversal: digit i of cnt weighted by B^(S-1-i), truncated to S digits.
    function automatic logic [63:0] model_point(input logic [31:0] cnt);
        logic [63:0] pt;
        logic [31:0] k, r, w;
        pt = '0;
        for (int d = 0; d < 2; d++) begin
            k = cnt;
            r = 0;
            for (int i = 0; i < int'(S[d]); i++) begin
                w = 1;
                for (int j = 0; j < int'(S[d]) - 1 - i; j++) w = w * B[d];
                r = r + (k % B[d]) * w;
                k = k / B[d];
            end
            pt[32*d +: 32] = r;
        end
        return pt;
    endfunction

    function automatic int calc_cycles(input logic [31:0] cnt);
        int total, n;
        logic [31:0] k;
        total = 0;
        for (int d = 0; d < 2; d++) begin
            k = cnt;
            n = 0;
            while (k != 0 && n < int'(S[d])) begin
                k = k / B[d];
                n++;
            end
            total += n + 1;
        end
        return total;
    endfunction

    // Issues a pop, pushes the expected point, waits for out_valid (bounded).
    task automatic do_pop(output logic [63:0] got, output int lat);
        pop_valid = 1'b1;
        @(negedge clk);
        pop_valid = 1'b0;
        model_count = model_count + 32'd1;
        exp_q.push_back(model_point(model_count));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout out_valid=%b after %0d cycles, required 1", out_valid, lat);
            got = 'x;
        end else begin
            got = out_data;
        end
        if (out_ready) @(negedge clk);
    endtask

    task automatic do_reseed(input logic [31:0] s);
        reseed_valid = 1'b1;
        seed = s;
        #1;
        checks++;
        if (reseed_ready !== 1'b1) begin
            errors++;
            $display("FAIL reseed_ready got %b required 1", reseed_ready);
        end
        @(negedge clk);
        reseed_valid = 1'b0;
        model_count = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pop_ready, reseed_ready, out_valid} !== 3'b000 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state rdy/vld=%b data=%h required 000/0",
                     {pop_ready, reseed_ready, out_valid}, out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({pop_ready, reseed_ready} !== 2'b11) begin
            errors++;
            $display("FAIL release_ready got %b required 11", {pop_ready, reseed_ready});
        end
        model_count = 0;
    endtask

    task automatic test_basic();
        logic [63:0] got, exp;
        int lat;
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== {32'd729, 32'd1024}) begin
            errors++;
            $display("FAIL first_point got %h required %h", got, exp);
        end
        checks++;
        if (lat !== 5 || lat !== calc_cycles(model_count) + 1) begin
            errors++;
            $display("FAIL first_latency got %0d required 5", lat);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse out_valid=%b required 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            do_pop(got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_point%0d got %h required %h", i, got, exp);
            end
            checks++;
            if (lat !== calc_cycles(model_count) + 1) begin
                errors++;
                $display("FAIL basic_latency%0d got %0d required %0d", i, lat,
                         calc_cycles(model_count) + 1);
            end
        end
    endtask

    task automatic test_reseed();
        logic [63:0] got, exp, prev;
        int lat;
        prev = out_data;
        do_reseed(32'd5);
        checks++;
        if (out_valid !== 1'b0 || out_data !== prev) begin
            errors++;
            $display("FAIL reseed_quiet vld=%b data=%h required 0/%h", out_valid, out_data, prev);
        end
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== {32'd486, 32'd768}) begin
            errors++;
            $display("FAIL reseed_point got %h required %h", got, exp);
        end
    endtask

    task automatic test_collision();
        logic [63:0] got, exp;
        int lat;
        pop_valid = 1'b1;
        reseed_valid = 1'b1;
        seed = 32'd0;
        #1;
        checks++;
        if ({pop_ready, reseed_ready} !== 2'b01) begin
            errors++;
            $display("FAIL collision_ready got %b required 01", {pop_ready, reseed_ready});
        end
        @(negedge clk);
        pop_valid = 1'b0;
        reseed_valid = 1'b0;
        model_count = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pop_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_idle vld=%b pop_ready=%b required 0/1", out_valid, pop_ready);
        end
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL collision_point got %h required %h", got, exp);
        end
    endtask

    task automatic test_hold();
        logic [63:0] got, exp;
        int lat;
        out_ready = 1'b0;
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL hold_point got %h required %h", got, exp);
        end
        pop_valid = 1'b1;
        reseed_valid = 1'b1;
        seed = 32'd123;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || {pop_ready, reseed_ready} !== 2'b00) begin
                errors++;
                $display("FAIL hold_stable%0d vld=%b data=%h rdy=%b required 1/%h/00",
                         i, out_valid, out_data, {pop_ready, reseed_ready}, exp);
            end
        end
        pop_valid = 1'b0;
        reseed_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pop_ready !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL hold_release vld=%b pop_ready=%b data=%h required 0/1/%h",
                     out_valid, pop_ready, out_data, exp);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] got, exp;
        int lat;
        do_reseed(32'hFFFF_FFFF);
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== 64'd0) begin
            errors++;
            $display("FAIL wrap_point got %h required %h", got, exp);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wrap_latency got %0d required 3", lat);
        end
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== {32'd729, 32'd1024}) begin
            errors++;
            $display("FAIL wrap_next got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        int lat;
        for (int n = 0; n < 6; n++) begin
            do_reseed($urandom);
            for (int i = 0; i < 2; i++) begin
                do_pop(got, lat);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_point count=%h got %h required %h", model_count, got, exp);
                end
                checks++;
                if (lat !== calc_cycles(model_count) + 1) begin
                    errors++;
                    $display("FAIL b2b_latency count=%h got %0d required %0d", model_count, lat,
                             calc_cycles(model_count) + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] got, exp, prev;
        int lat;
        prev = out_data;
        pop_valid = 1'b1;
        @(negedge clk);
        pop_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data !== prev || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL calc_lanes_kept data=%h vld=%b required %h/0", out_data, out_valid, prev);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || {pop_ready, reseed_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midcalc_reset vld=%b data=%h rdy=%b required 0/0/00",
                     out_valid, out_data, {pop_ready, reseed_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_count = 0;
        exp_q.delete();
        do_pop(got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== {32'd729, 32'd1024}) begin
            errors++;
            $display("FAIL midcalc_next got %h required %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reseed();
        test_collision();
        test_hold();
        test_wrap();
        test_back_to_back();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
